// File: rtl/sprite_compositor_if.sv
// Sprite compositor bus: descriptor writes, pixel coordinate stream,
// sprite memory read port and colour output.
// master = the side that drives pixels/writes and serves memory reads,
// slave  = the compositor itself.
interface sprite_compositor_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 9,
  parameter int ADDR_W  = 14
);
  logic               wr_en;
  logic [31:0]        dataA;
  logic [31:0]        dataB;
  logic               wr_err;
  logic               frame_start;
  logic               pix_valid;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic               active_area;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [COLOR_W-1:0] mem_rdata;
  logic [COLOR_W-1:0] color_out;
  logic               color_valid;

  modport master (
    output wr_en, dataA, dataB, frame_start, pix_valid, pixel_x, pixel_y,
           active_area, mem_rdata,
    input  wr_err, mem_addr, mem_rd, color_out, color_valid
  );

  modport slave (
    input  wr_en, dataA, dataB, frame_start, pix_valid, pixel_x, pixel_y,
           active_area, mem_rdata,
    output wr_err, mem_addr, mem_rd, color_out, color_valid
  );
endinterface

// File: rtl/sprite_compositor.sv
// N-slot sprite compositor: per-pixel hit test against the active
// descriptor bank, sprite memory address generation, colour select.
// Three pipeline stages, one pixel per cycle, fixed 3-cycle latency.
// Optional feature: SPRITE_DOUBLE_BUFFER_EN adds a shadow bank that is
// committed to the active bank on frame_start.
module sprite_compositor #(
  parameter int N_SPRITES = 8,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int ID_W      = 5,
  parameter int SPR_DIM   = 20,
  parameter int COLOR_W   = 9,
  parameter int ADDR_W    = 14,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 9'h1FF
) (
  input logic clk,
  input logic reset,
  sprite_compositor_if.slave bus
);

  localparam int XE_W = X_W + 1;
  localparam int YE_W = Y_W + 1;
  localparam logic [7:0] BG_IDX = 8'(N_SPRITES);

  typedef struct packed {
    logic            en;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [ID_W-1:0] id;
  } slot_t;

  slot_t              act_q [N_SPRITES];
  slot_t              act_d [N_SPRITES];
  logic [COLOR_W-1:0] bg_q, bg_d;
`ifdef SPRITE_DOUBLE_BUFFER_EN
  slot_t              shd_q [N_SPRITES];
  slot_t              shd_d [N_SPRITES];
  logic [COLOR_W-1:0] shd_bg_q, shd_bg_d;
`endif

  logic [7:0] wr_idx;
  slot_t      wr_slot;
  logic       wr_err_q, wr_err_d;

  logic [N_SPRITES-1:0] slot_hit;
  logic                 win_hit;
  logic [ID_W-1:0]      win_id;
  logic [X_W-1:0]       win_dx;
  logic [Y_W-1:0]       win_dy;

  logic               s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
  logic               s1_active_q, s1_active_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [X_W-1:0]     s1_dx_q, s1_dx_d;
  logic [Y_W-1:0]     s1_dy_q, s1_dy_d;
  logic [COLOR_W-1:0] s1_bg_q, s1_bg_d;
  logic               s2_valid_q, s2_valid_d, s2_hit_q, s2_hit_d;
  logic               s2_active_q, s2_active_d;
  logic [COLOR_W-1:0] s2_bg_q, s2_bg_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [COLOR_W-1:0] color_out_q, color_out_d;
  logic               color_valid_q, color_valid_d;

  assign wr_idx  = bus.dataA[7:0];
  assign wr_slot = {bus.dataB[31], bus.dataB[ID_W+Y_W +: X_W],
                    bus.dataB[ID_W +: Y_W], bus.dataB[ID_W-1:0]};

  // Descriptor writes into the written bank; optional commit on frame_start
  // that already includes a write landing in the same cycle.
  always_comb begin
    act_d    = act_q;
    bg_d     = bg_q;
    wr_err_d = bus.wr_en && (wr_idx > BG_IDX);
`ifdef SPRITE_DOUBLE_BUFFER_EN
    shd_d    = shd_q;
    shd_bg_d = shd_bg_q;
    if (bus.wr_en) begin
      for (int i = 0; i < N_SPRITES; i++)
        if (wr_idx == 8'(i)) shd_d[i] = wr_slot;
      if (wr_idx == BG_IDX) shd_bg_d = bus.dataB[COLOR_W-1:0];
    end
    if (bus.frame_start) begin
      act_d = shd_d;
      bg_d  = shd_bg_d;
    end
`else
    if (bus.wr_en) begin
      for (int i = 0; i < N_SPRITES; i++)
        if (wr_idx == 8'(i)) act_d[i] = wr_slot;
      if (wr_idx == BG_IDX) bg_d = bus.dataB[COLOR_W-1:0];
    end
`endif
  end

  // Per-slot hit test in widened arithmetic so edge sprites clip, not wrap.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      slot_hit[i] = act_q[i].en
        && ({1'b0, bus.pixel_x} >= {1'b0, act_q[i].x})
        && ({1'b0, bus.pixel_x} < ({1'b0, act_q[i].x} + XE_W'(SPR_DIM)))
        && ({1'b0, bus.pixel_y} >= {1'b0, act_q[i].y})
        && ({1'b0, bus.pixel_y} < ({1'b0, act_q[i].y} + YE_W'(SPR_DIM)));
    end
  end

  // Priority select: scan high to low so the lowest hitting slot wins.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        win_hit = 1'b1;
        win_id  = act_q[i].id;
        win_dx  = bus.pixel_x - act_q[i].x;
        win_dy  = bus.pixel_y - act_q[i].y;
      end
    end
  end

  // Pipeline next-state: S1 hit/offsets, S2 memory address, S3 colour.
  always_comb begin
    s1_valid_d  = bus.pix_valid;
    s1_hit_d    = win_hit;
    s1_active_d = bus.active_area;
    s1_id_d     = win_id;
    s1_dx_d     = win_dx;
    s1_dy_d     = win_dy;
    s1_bg_d     = bg_q;

    s2_valid_d  = s1_valid_q;
    s2_hit_d    = s1_hit_q;
    s2_active_d = s1_active_q;
    s2_bg_d     = s1_bg_q;
    mem_rd_d    = s1_valid_q && s1_hit_q && s1_active_q;
    mem_addr_d  = mem_addr_q;
    if (s1_valid_q)
      mem_addr_d = ADDR_W'(s1_id_q) * ADDR_W'(SPR_DIM * SPR_DIM)
                 + ADDR_W'(s1_dy_q) * ADDR_W'(SPR_DIM)
                 + ADDR_W'(s1_dx_q);

    color_valid_d = s2_valid_q;
    color_out_d   = color_out_q;
    if (s2_valid_q) begin
      if (!s2_active_q)
        color_out_d = '0;
      else if (!s2_hit_q || bus.mem_rdata == TRANSPARENT)
        color_out_d = s2_bg_q;
      else
        color_out_d = bus.mem_rdata;
    end
  end

  // State registers; reset clears the banks and flushes in-flight pixels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) act_q[i] <= '0;
      bg_q <= '0;
`ifdef SPRITE_DOUBLE_BUFFER_EN
      for (int i = 0; i < N_SPRITES; i++) shd_q[i] <= '0;
      shd_bg_q <= '0;
`endif
      wr_err_q      <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_hit_q      <= 1'b0;
      s1_active_q   <= 1'b0;
      s1_id_q       <= '0;
      s1_dx_q       <= '0;
      s1_dy_q       <= '0;
      s1_bg_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_hit_q      <= 1'b0;
      s2_active_q   <= 1'b0;
      s2_bg_q       <= '0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      color_out_q   <= '0;
      color_valid_q <= 1'b0;
    end else begin
      act_q <= act_d;
      bg_q  <= bg_d;
`ifdef SPRITE_DOUBLE_BUFFER_EN
      shd_q    <= shd_d;
      shd_bg_q <= shd_bg_d;
`endif
      wr_err_q      <= wr_err_d;
      s1_valid_q    <= s1_valid_d;
      s1_hit_q      <= s1_hit_d;
      s1_active_q   <= s1_active_d;
      s1_id_q       <= s1_id_d;
      s1_dx_q       <= s1_dx_d;
      s1_dy_q       <= s1_dy_d;
      s1_bg_q       <= s1_bg_d;
      s2_valid_q    <= s2_valid_d;
      s2_hit_q      <= s2_hit_d;
      s2_active_q   <= s2_active_d;
      s2_bg_q       <= s2_bg_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      color_out_q   <= color_out_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign bus.wr_err      = wr_err_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.color_out   = color_out_q;
  assign bus.color_valid = color_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: hand-computed addresses/colours.
module tb_sprite_compositor;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_compositor_if #(.X_W(10), .Y_W(9), .COLOR_W(9), .ADDR_W(14)) bus ();

  sprite_compositor #(
    .N_SPRITES(8), .X_W(10), .Y_W(9), .ID_W(5), .SPR_DIM(20),
    .COLOR_W(9), .ADDR_W(14), .TRANSPARENT(9'h1FF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot(input bit en, input int x,
                                       input int y, input int id);
    return {en, 7'b0, 10'(x), 9'(y), 5'(id)};
  endfunction

  // Write with frame_start asserted alongside (commits in buffered builds).
  task automatic wr(input int idx, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.dataA = 32'(idx); bus.dataB = d;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.frame_start = 1'b0;
    check("wr_err_none", {31'b0, bus.wr_err}, 32'd0);
  endtask

  task automatic wr_nc(input int idx, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.dataA = 32'(idx); bus.dataB = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input bit act, input bit exp_rd, input int exp_addr,
                     input int exp_col);
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.pixel_x = 10'(x); bus.pixel_y = 9'(y);
    bus.active_area = act;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rd"}, {31'b0, bus.mem_rd}, {31'b0, exp_rd});
    if (exp_rd) check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
    check({tag, "_early"}, {31'b0, bus.color_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_cv"}, {31'b0, bus.color_valid}, 32'd1);
    check({tag, "_col"}, 32'(bus.color_out), 32'(exp_col));
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_en = 0; bus.dataA = 0; bus.dataB = 0; bus.frame_start = 0;
    bus.pix_valid = 0; bus.pixel_x = 0; bus.pixel_y = 0;
    bus.active_area = 0; bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_cv",   {31'b0, bus.color_valid}, 32'd0);
    check("rst_rd",   {31'b0, bus.mem_rd}, 32'd0);
    check("rst_err",  {31'b0, bus.wr_err}, 32'd0);
    check("rst_col",  32'(bus.color_out), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b1;

    // Background only
    wr(8, 32'h038);
    pix("bg", 5, 5, 1, 0, 0, 'h038);

    // Single sprite hit
    wr(2, slot(1, 100, 50, 3));
    bus.mem_rdata = 9'h007;
    pix("s2", 105, 52, 1, 1, 1245, 'h007);

    // Priority and transparency
    wr(0, slot(1, 8, 8, 1));
    wr(1, slot(1, 0, 0, 4));
    bus.mem_rdata = 9'h1FF;
    pix("prio_tr", 10, 10, 1, 1, 442, 'h038);
    bus.mem_rdata = 9'h0AA;
    pix("prio", 10, 10, 1, 1, 442, 'h0AA);

    // Edge clipping
    wr(1, 32'h0);
    wr(0, slot(1, 630, 0, 0));
    bus.mem_rdata = 9'h055;
    pix("x639", 639, 5, 1, 1, 109, 'h055);
    pix("x650", 650, 5, 1, 0, 0, 'h038);
    pix("x0",   0,   5, 1, 0, 0, 'h038);
    wr(0, slot(1, 1010, 0, 0));
    pix("xwrap", 1020, 5, 1, 1, 110, 'h055);
    wr(0, slot(1, 0, 500, 0));
    pix("ywrap", 0, 511, 1, 1, 220, 'h055);
    pix("ylow",  0, 499, 1, 0, 0, 'h038);
    wr(0, slot(1, 1010, 0, 0));

    // Out-of-range write
    @(negedge clk);
    bus.wr_en = 1'b1; bus.dataA = 32'd9; bus.dataB = slot(1, 0, 0, 7);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("wr_err_pulse", {31'b0, bus.wr_err}, 32'd1);
    @(negedge clk);
    check("wr_err_end", {31'b0, bus.wr_err}, 32'd0);
    pix("after_err_hit", 1020, 5, 1, 1, 110, 'h055);
    pix("after_err_bg",  0,    5, 1, 0, 0, 'h038);

    // Outside visible area
    pix("inactive", 1020, 5, 0, 0, 0, 'h000);

    // Back-to-back pixels, then a gap
    @(negedge clk);
    bus.pix_valid = 1; bus.pixel_x = 10'd1020; bus.pixel_y = 9'd5;
    bus.active_area = 1;
    @(negedge clk);
    bus.pixel_x = 10'd0;
    @(negedge clk);
    bus.pix_valid = 0;
    check("b2b_rd_a",   {31'b0, bus.mem_rd}, 32'd1);
    check("b2b_addr_a", 32'(bus.mem_addr), 32'd110);
    @(negedge clk);
    check("b2b_rd_b",  {31'b0, bus.mem_rd}, 32'd0);
    check("b2b_cv_a",  {31'b0, bus.color_valid}, 32'd1);
    check("b2b_col_a", 32'(bus.color_out), 32'h055);
    @(negedge clk);
    check("b2b_cv_b",  {31'b0, bus.color_valid}, 32'd1);
    check("b2b_col_b", 32'(bus.color_out), 32'h038);
    @(negedge clk);
    check("b2b_gap",  {31'b0, bus.color_valid}, 32'd0);
    check("b2b_hold", 32'(bus.color_out), 32'h038);

    // Reset with pixels in flight
    @(negedge clk);
    bus.pix_valid = 1; bus.pixel_x = 10'd1020; bus.pixel_y = 9'd5;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.pix_valid = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("flush_cv", {31'b0, bus.color_valid}, 32'd0);
      @(negedge clk);
    end
    pix("post_rst", 1020, 5, 1, 0, 0, 'h000);

    bus.mem_rdata = 9'h0F0;
`ifdef SPRITE_DOUBLE_BUFFER_EN
    wr(0, slot(1, 0, 0, 2));
    pix("db_fwd", 3, 3, 1, 1, 863, 'h0F0);
    wr_nc(0, slot(1, 200, 0, 2));
    pix("db_old_pos", 3,   3, 1, 1, 863, 'h0F0);
    pix("db_new_pend", 203, 3, 1, 0, 0, 'h000);
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    pix("db_new_pos", 203, 3, 1, 1, 863, 'h0F0);
    pix("db_old_gone", 3,  3, 1, 0, 0, 'h000);
`else
    wr_nc(0, slot(1, 0, 0, 2));
    pix("nb_immediate", 3, 3, 1, 1, 863, 'h0F0);
    wr_nc(0, slot(0, 0, 0, 2));
    pix("nb_disable", 3, 3, 1, 0, 0, 'h000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite compositing pipeline for the video processor: holds `N_SPRITES` sprite descriptors plus a background colour, and converts a raster pixel coordinate stream into a colour stream by selecting the highest-priority sprite covering each pixel. It issues the sprite-memory read address itself and returns one colour per pixel at a fixed 3-cycle latency. It sits between the instruction decoder and the VGA colour output, and replaces the single-sprite print path with an N-channel one.

## Interface
Parameters:
- `N_SPRITES`, 8: number of sprite slots; slot 0 has the highest priority.
- `X_W`, 10: pixel x width.
- `Y_W`, 9: pixel y width.
- `ID_W`, 5: sprite image index width.
- `SPR_DIM`, 20: sprite edge in pixels; sprites are square.
- `COLOR_W`, 9: colour width as {B,G,R}.
- `ADDR_W`, 14: sprite memory address width.
- `TRANSPARENT`, 9'h1FF: colour code treated as see-through.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  descriptor write strobe.
- `dataA`  in  32  write index; `dataA[7:0]` is used.
- `dataB`  in  32  write data.
- `wr_err`  out  1  one-cycle pulse when a write targets an out-of-range index.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank.
- `pix_valid`  in  1  pixel-coordinate strobe.
- `pixel_x`  in  X_W  pixel x coordinate.
- `pixel_y`  in  Y_W  pixel y coordinate.
- `active_area`  in  1  pixel is inside the visible area.
- `mem_addr`  out  ADDR_W  sprite memory read address.
- `mem_rd`  out  1  sprite memory read strobe.
- `mem_rdata`  in  COLOR_W  sprite memory data; arrives one cycle after `mem_addr`.
- `color_out`  out  COLOR_W  output colour.
- `color_valid`  out  1  `color_out` is valid.

## Operation
- **Descriptor write** (index = `dataA[7:0]`):
  - Index < `N_SPRITES`: writes slot `index`.
  - Index == `N_SPRITES`: writes the background colour, `dataB[COLOR_W-1:0]`.
  - Any larger index: write ignored, `wr_err` pulses on the next cycle.
- **Slot layout** in `dataB`:
  - `[ID_W-1:0]` = id
  - `[ID_W +: Y_W]` = y
  - `[ID_W+Y_W +: X_W]` = x
  - `[31]` = enable
- **Hit test**, per enabled slot: `x <= px < x+SPR_DIM` and `y <= py < y+SPR_DIM`.
  - Compare in X_W+1 / Y_W+1 bits, so sprites at the right or bottom edge clip and never wrap to column or row 0.
  - The lowest hitting slot index wins.
- **Address**: `id*SPR_DIM*SPR_DIM + (py-y)*SPR_DIM + (px-x)`, truncated to ADDR_W.
- **Colour select**:
  - `active_area`=0 gives 0.
  - No hit, or `mem_rdata`==`TRANSPARENT`, gives the background colour.
  - Otherwise `mem_rdata`.
- **Pipeline**, no FSM; each stage carries its own valid bit:
  - S1 registers hit, winning id, dx, dy and active.
  - S2 registers `mem_addr` and `mem_rd` (`mem_rd` = S1 valid & hit & active).
  - S3 registers `color_out` and `color_valid`.
- **Reset**:
  - All slot enables cleared, background = 0.
  - All valids, `mem_rd`, `wr_err`, `color_valid`, `color_out` and `mem_addr` are 0.
  - Reset mid-frame flushes in-flight pixels; no `color_valid` is produced for them.

## Timing
- `pix_valid` at cycle T gives `color_valid`=1 at T+3; fully pipelined, one pixel per cycle, no stalls.
- `mem_addr` and `mem_rd` are valid at T+2; the memory returns data at T+3 and S3 samples it on that edge.
- A gap in `pix_valid` propagates as a gap in `color_valid`. `color_out` holds its last value when not valid.
- Writes take effect in the active set at the point defined in Configuration. A hit test at cycle T uses the active set as of cycle T.
- `wr_en` and `frame_start` in the same cycle: the write is forwarded into the commit.

## Configuration
- `SPRITE_DOUBLE_BUFFER_EN` defined:
  - Writes land in a shadow bank.
  - On `frame_start` the whole shadow bank (slots and background) copies to the active bank in one cycle.
  - The active bank never changes mid-frame.
- Not defined:
  - No shadow bank; writes update the active bank on the next posedge.
  - `frame_start` is ignored.

## Test plan
- Reset, then `pix_valid` with `active_area`=1 at (5,5), no slots enabled, background written 9'h038 → `color_out`=9'h038 with `color_valid` exactly 3 cycles later, `mem_rd`=0.
- Slot 2 = {en=1, x=100, y=50, id=3}; pixel (105,52) → `mem_addr`=3·400+2·20+5=1245 at T+2; `mem_rdata`=9'h007 → `color_out`=9'h007 at T+3.
- Slots 0 and 1 both cover (10,10) with ids 1 and 4 → address from id 1; with `mem_rdata`=9'h1FF → background.
- Slot 0 at x=630 (`X_W`=10): pixel 639 hits, pixel 0 does not; write to index 9 with `N_SPRITES`=8 → `wr_err` pulse, state unchanged.
- With `SPRITE_DOUBLE_BUFFER_EN`, move slot 0 mid-frame → old position is used until `frame_start`, new position from the next pixel on; write coinciding with `frame_start` is visible in that frame. Apply reset mid-stream → no `color_valid` for pixels in flight.
